cpu_commit_monitor: RTL

- Synthesizable observer sitting directly downstream of the mipscpu core.
- Consumes the core's per-instruction commit and register-file write signals.
- Maintains cycle and retired-instruction counters and buffers register writebacks in a trace FIFO drained by a ready/valid port.
- Detects the branch-to-self halt idiom, so a simulation bench or board logic can stop cleanly and dump state.

---
 rtl/cpu_commit_monitor.sv | 205 ++++++++++++++++++++
 1 files changed

// File: rtl/cpu_commit_monitor.sv
// ============================================================================
//  Module      : cpu_commit_monitor
//  Description : Commit observer for the mipscpu core. Counts cycles and
//                retired instructions, traces register writebacks into a
//                first-word-fall-through FIFO drained over a ready/valid
//                port, and detects the branch-to-self halt idiom.
//                Optional build macro TRACE_MEMWR_EN adds data-memory write
//                tracing (dm_* inputs, trace_kind / trace_maddr outputs).
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module cpu_commit_monitor #(
    parameter int DEPTH       = 16,
    parameter int HALT_REPEAT = 3,
    parameter int CNT_W       = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             commit_valid,
    input  logic [31:0]      commit_pc,
    input  logic             rf_we,
    input  logic [4:0]       rf_addr,
    input  logic [31:0]      rf_wdata,
`ifdef TRACE_MEMWR_EN
    input  logic             dm_we,
    input  logic [31:0]      dm_addr,
    input  logic [31:0]      dm_wdata,
    output logic             trace_kind,
    output logic [31:0]      trace_maddr,
`endif
    output logic             trace_valid,
    input  logic             trace_ready,
    output logic [31:0]      trace_pc,
    output logic [4:0]       trace_addr,
    output logic [31:0]      trace_data,
    output logic [CNT_W-1:0] cycle_count,
    output logic [CNT_W-1:0] retire_count,
    output logic             halted,
    output logic             overflow
);

    localparam int AW   = $clog2(DEPTH);
    localparam int RC_W = $clog2(HALT_REPEAT + 1);
    localparam logic [RC_W-1:0] c_HALT_REP = RC_W'(HALT_REPEAT);
    localparam logic [RC_W-1:0] c_REP_ONE  = RC_W'(1);

    typedef enum logic [0:0] {
        RUN    = 1'b0,
        HALTED = 1'b1
    } state_t;

    state_t r_state;
    state_t w_state_next;

    logic [CNT_W-1:0] r_cycle;
    logic [CNT_W-1:0] r_retire;
    logic [31:0]      r_last_pc;
    logic [RC_W-1:0]  r_rep_cnt;
    logic [RC_W-1:0]  w_rep_next;
    logic             w_run;
    logic             w_halt_hit;

    // FIFO storage and pointers (one extra MSB distinguishes full from empty)
    logic [31:0] r_mem_pc   [DEPTH];
    logic [4:0]  r_mem_addr [DEPTH];
    logic [31:0] r_mem_data [DEPTH];
    logic [AW:0] r_wptr;
    logic [AW:0] r_rptr;
    logic        r_overflow;

    logic          w_full;
    logic          w_empty;
    logic          w_pop;
    logic          w_push_req;
    logic          w_push_ok;
    logic          w_drop;
    logic          w_collide;
    logic          w_rf_push;
    logic [AW-1:0] w_wr_idx;
    logic [AW-1:0] w_rd_idx;
    logic [4:0]    w_in_addr;
    logic [31:0]   w_in_data;

    assign w_run    = (r_state == RUN);
    assign w_wr_idx = r_wptr[AW-1:0];
    assign w_rd_idx = r_rptr[AW-1:0];
    assign w_empty  = (r_wptr == r_rptr);
    assign w_full   = (r_wptr[AW] != r_rptr[AW]) && (w_wr_idx == w_rd_idx);
    assign w_pop    = !w_empty && trace_ready;

    // Writes to $zero carry no architectural information and are never traced
    assign w_rf_push = commit_valid && rf_we && (rf_addr != 5'd0);

`ifdef TRACE_MEMWR_EN
    logic        r_mem_kind  [DEPTH];
    logic [31:0] r_mem_maddr [DEPTH];
    logic        w_mem_push;
    logic        w_in_kind;
    logic [31:0] w_in_maddr;

    // A register write wins over a simultaneous memory write; the loser is dropped
    assign w_mem_push = commit_valid && dm_we;
    assign w_push_req = w_run && (w_rf_push || w_mem_push);
    assign w_collide  = w_run && w_rf_push && w_mem_push;
    assign w_in_addr  = w_rf_push ? rf_addr  : 5'd0;
    assign w_in_data  = w_rf_push ? rf_wdata : dm_wdata;
    assign w_in_kind  = !w_rf_push;
    assign w_in_maddr = w_rf_push ? 32'd0 : dm_addr;
`else
    assign w_push_req = w_run && w_rf_push;
    assign w_collide  = 1'b0;
    assign w_in_addr  = rf_addr;
    assign w_in_data  = rf_wdata;
`endif

    // When full, a push is only accepted if the head leaves on the same edge
    assign w_push_ok = w_push_req && (!w_full || w_pop);
    assign w_drop    = (w_push_req && w_full && !w_pop) || w_collide;

    // Repeat counter saturates so a long spin never wraps back below the limit
    assign w_rep_next = (commit_pc == r_last_pc)
                      ? ((r_rep_cnt == c_HALT_REP) ? c_HALT_REP : r_rep_cnt + c_REP_ONE)
                      : c_REP_ONE;
    assign w_halt_hit = w_run && commit_valid && (w_rep_next == c_HALT_REP);

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= RUN;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state: RUN falls into HALTED on the halting commit; only reset leaves HALTED
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            RUN:     if (w_halt_hit) w_state_next = HALTED;
            HALTED:  w_state_next = HALTED;
            default: w_state_next = RUN;
        endcase
    end

    // Cycle / retire counters and halt-idiom tracking, all frozen outside RUN
    always_ff @(posedge clk) begin
        if (reset) begin
            r_cycle   <= '0;
            r_retire  <= '0;
            r_last_pc <= '0;
            r_rep_cnt <= '0;
        end else if (w_run) begin
            r_cycle <= r_cycle + 1'b1;
            if (commit_valid) begin
                r_retire  <= r_retire + 1'b1;
                r_last_pc <= commit_pc;
                r_rep_cnt <= w_rep_next;
            end
        end
    end

    // FIFO pointers and sticky overflow flag
    always_ff @(posedge clk) begin
        if (reset) begin
            r_wptr     <= '0;
            r_rptr     <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_push_ok) r_wptr <= r_wptr + 1'b1;
            if (w_pop)     r_rptr <= r_rptr + 1'b1;
            if (w_drop)    r_overflow <= 1'b1;
        end
    end

    // FIFO storage write port; contents are don't-care until a pointer covers them
    always_ff @(posedge clk) begin
        if (w_push_ok) begin
            r_mem_pc[w_wr_idx]   <= commit_pc;
            r_mem_addr[w_wr_idx] <= w_in_addr;
            r_mem_data[w_wr_idx] <= w_in_data;
`ifdef TRACE_MEMWR_EN
            r_mem_kind[w_wr_idx]  <= w_in_kind;
            r_mem_maddr[w_wr_idx] <= w_in_maddr;
`endif
        end
    end

    // Head is shown straight from storage and masked to zero while empty
    assign trace_valid  = !w_empty;
    assign trace_pc     = w_empty ? 32'd0 : r_mem_pc[w_rd_idx];
    assign trace_addr   = w_empty ? 5'd0  : r_mem_addr[w_rd_idx];
    assign trace_data   = w_empty ? 32'd0 : r_mem_data[w_rd_idx];
`ifdef TRACE_MEMWR_EN
    assign trace_kind   = w_empty ? 1'b0  : r_mem_kind[w_rd_idx];
    assign trace_maddr  = w_empty ? 32'd0 : r_mem_maddr[w_rd_idx];
`endif
    assign cycle_count  = r_cycle;
    assign retire_count = r_retire;
    assign halted       = (r_state == HALTED);
    assign overflow     = r_overflow;

endmodule

`default_nettype wire
